// File: rtl/truth_table_scanner.sv
// Clocked truth-table scan: walks every input vector into a combinational gate, samples
// its output after a settle delay and compares it against a golden table.
module truth_table_scanner #(
  parameter int unsigned              N_IN     = 2,
  parameter logic [(1<<N_IN)-1:0]     EXPECTED = 4'b1101,
  parameter int unsigned              SETTLE   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    dut_s,
  output logic [N_IN-1:0]         vec,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [N_IN:0]           err_count,
  output logic                    first_err_valid,
  output logic [N_IN-1:0]         first_err_idx,
  output logic [(1<<N_IN)-1:0]    result_table
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  state_t                  state_q;
  logic [N_IN-1:0]         vec_q;
  logic [CW-1:0]           cnt_q;
  logic                    busy_q;
  logic                    done_q;
  logic                    pass_q;
  logic [N_IN:0]           err_q;
  logic                    fev_q;
  logic [N_IN-1:0]         fidx_q;
  logic [(1<<N_IN)-1:0]    table_q;

  logic                    mismatch;
  logic [N_IN:0]           err_d;

  always_comb begin
    mismatch = (dut_s != EXPECTED[vec_q]);
    err_d    = err_q + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fev_q   <= 1'b0;
      fidx_q  <= '0;
      table_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= DRIVE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            fev_q   <= 1'b0;
            fidx_q  <= '0;
            table_q <= '0;
          end
        end
        DRIVE: begin
          if (cnt_q == CW'(SETTLE - 1)) state_q <= SAMPLE;
          else                          cnt_q   <= cnt_q + CW'(1);
        end
        SAMPLE: begin
          table_q[vec_q] <= dut_s;
          err_q          <= err_d;
          if (mismatch && !fev_q) begin
            fev_q  <= 1'b1;
            fidx_q <= vec_q;
          end
          // pass uses the count including this last vector's comparison
          if (vec_q == '1) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == '0);
          end else begin
            vec_q   <= vec_q + N_IN'(1);
            cnt_q   <= '0;
            state_q <= DRIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_q;
  assign first_err_idx   = fidx_q;
  assign result_table    = table_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) exercised with
// directed and random fault tables, noisy dut_s between sample points, resets and restarts.
module tb_truth_table_scanner;

  localparam int unsigned N   = 2;
  localparam logic [3:0]  EXP = 4'b1101;

  logic clk = 1'b0;
  logic rst_n, start, sel, dut_s;
  logic start_a, start_b;

  logic [1:0] vec_a, vec_b, fidx_a, fidx_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fev_a, fev_b;
  logic [2:0] err_a, err_b;
  logic [3:0] tab_a, tab_b;

  logic [1:0] o_vec, o_fidx;
  logic       o_busy, o_done, o_pass, o_fev;
  logic [2:0] o_err;
  logic [3:0] o_tab;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;

  assign o_vec  = sel ? vec_b  : vec_a;
  assign o_fidx = sel ? fidx_b : fidx_a;
  assign o_busy = sel ? busy_b : busy_a;
  assign o_done = sel ? done_b : done_a;
  assign o_pass = sel ? pass_b : pass_a;
  assign o_fev  = sel ? fev_b  : fev_a;
  assign o_err  = sel ? err_b  : err_a;
  assign o_tab  = sel ? tab_b  : tab_a;

  truth_table_scanner #(.N_IN(2), .EXPECTED(4'b1101), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_s(dut_s),
    .vec(vec_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
    .first_err_valid(fev_a), .first_err_idx(fidx_a), .result_table(tab_a)
  );

  truth_table_scanner #(.N_IN(2), .EXPECTED(4'b1101), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_s(dut_s),
    .vec(vec_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
    .first_err_valid(fev_b), .first_err_idx(fidx_b), .result_table(tab_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input bit b, input string tag);
    sel = b;
    #1;
    chk({tag, " vec"},   32'(o_vec),  0);
    chk({tag, " busy"},  32'(o_busy), 0);
    chk({tag, " done"},  32'(o_done), 0);
    chk({tag, " pass"},  32'(o_pass), 0);
    chk({tag, " err"},   32'(o_err),  0);
    chk({tag, " fev"},   32'(o_fev),  0);
    chk({tag, " fidx"},  32'(o_fidx), 0);
    chk({tag, " table"}, 32'(o_tab),  0);
  endtask

  // One scan: fault[v]=1 means the gate answers wrongly for vector v. The expected
  // state after j cycles follows from "vector v is sampled on edge (v+1)*(S+1)".
  task automatic run_scan(input bit b, input logic [3:0] fault, input bit noise,
                          input bit hold, input int pulse_at);
    int unsigned S, L, nsamp, v, first;
    logic [3:0] mask, golden;
    S      = b ? 3 : 1;
    L      = 4 * (S + 1);
    golden = EXP ^ fault;
    sel    = b;
    start  = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int unsigned j = 0; j < L; j++) begin
      nsamp = j / (S + 1);
      v     = nsamp;
      mask  = (4'd1 << nsamp) - 4'd1;
      chk("scan vec",   32'(o_vec),  32'(v));
      chk("scan busy",  32'(o_busy), 1);
      chk("scan done",  32'(o_done), 0);
      chk("scan pass",  32'(o_pass), 0);
      chk("scan err",   32'(o_err),  32'($countones(fault & mask)));
      chk("scan fev",   32'(o_fev),  32'((fault & mask) != 4'd0));
      chk("scan table", 32'(o_tab),  32'(golden & mask));
      if (!noise || (j % (S + 1)) == S) dut_s = golden[v];
      else                              dut_s = 1'($urandom_range(0, 1));
      if (int'(j) == pulse_at) start = 1'b1;
      else if (!hold)          start = 1'b0;
      @(posedge clk); #1;
    end
    first = 0;
    for (int unsigned i = 4; i > 0; i--) if (fault[i-1]) first = i - 1;
    chk("end done",  32'(o_done), 1);
    chk("end busy",  32'(o_busy), 0);
    chk("end vec",   32'(o_vec),  3);
    chk("end table", 32'(o_tab),  32'(golden));
    chk("end err",   32'(o_err),  32'($countones(fault)));
    chk("end fev",   32'(o_fev),  32'(fault != 4'd0));
    chk("end fidx",  32'(o_fidx), 32'(first));
    chk("end pass",  32'(o_pass), 32'(fault == 4'd0));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    dut_s = 1'b0;
    repeat (2) @(posedge clk);
    chk_reset(0, "rst a");
    chk_reset(1, "rst b");
    @(negedge clk);
    rst_n = 1'b1;

    run_scan(0, 4'b0000, 1, 0, -1);
    sel = 0; #1;
    chk("done level", 32'(o_done), 1);
    run_scan(0, EXP,     0, 0, -1);
    run_scan(0, 4'b0100, 1, 0, -1);
    run_scan(0, 4'b0000, 1, 0, 3);
    run_scan(0, 4'b1000, 1, 0, 5);

    sel   = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    chk_reset(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_scan(0, 4'b0000, 1, 0, -1);

    for (int k = 0; k < 6; k++) run_scan(0, 4'($urandom_range(0, 15)), 1, 0, -1);

    run_scan(1, 4'b0000, 1, 1, -1);
    run_scan(1, 4'($urandom_range(1, 15)), 1, 1, -1);
    run_scan(1, 4'b0000, 1, 0, -1);
    run_scan(1, 4'b0110, 1, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
